// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: round-robin two-port controller with sub-word load/store over a word RAM
module dmem_access_ctrl #(
  parameter int DEPTH_LOG2 = 6,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_W-1:0]     req0_addr,
  input  logic [31:0]           req0_wdata,
  input  logic [1:0]            req0_size,
  input  logic                  req0_unsigned,
  output logic                  rsp0_valid,
  output logic [31:0]           rsp0_rdata,
  output logic                  rsp0_err,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_W-1:0]     req1_addr,
  input  logic [31:0]           req1_wdata,
  input  logic [1:0]            req1_size,
  input  logic                  req1_unsigned,
  output logic                  rsp1_valid,
  output logic [31:0]           rsp1_rdata,
  output logic                  rsp1_err,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, MERGE = 2'd2, RESP = 2'd3;
  logic [1:0] state, state_nx, q_size, s_size;
  logic rr_last, q_we, q_uns, q_port, q_err;
  logic any_valid, gnt, idle, rsp_on, s_we, s_uns, s_err;
  logic [DEPTH_LOG2+1:0] q_addr;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0] q_wdata, old_word, rdata_q, s_wdata, lane_sh, load_val, lane_mask, merged;
  logic [4:0] shamt;
  // Grant selection, request mux, lane extraction/merge and output decode
  always_comb begin
    any_valid = req0_valid | req1_valid;
    gnt = (req0_valid & req1_valid) ? ~rr_last : req1_valid;
    idle = reset_n & (state == IDLE);
    req0_ready = idle & any_valid & ~gnt;
    req1_ready = idle & any_valid & gnt;
    s_we = gnt ? req1_we : req0_we;
    s_addr = gnt ? req1_addr : req0_addr;
    s_wdata = gnt ? req1_wdata : req0_wdata;
    s_size = gnt ? req1_size : req0_size;
    s_uns = gnt ? req1_unsigned : req0_unsigned;
    s_err = (s_size == 2'b11) | (s_size == 2'b01 & s_addr[0]) | (s_size == 2'b10 & |s_addr[1:0]) | (|s_addr[ADDR_W-1:DEPTH_LOG2+2]);
    shamt = {q_addr[1:0], 3'b000};
    lane_sh = mem_rdata >> shamt;
    load_val = q_size == 2'b00 ? {{24{~q_uns & lane_sh[7]}}, lane_sh[7:0]} : q_size == 2'b01 ? {{16{~q_uns & lane_sh[15]}}, lane_sh[15:0]} : lane_sh;
    lane_mask = (q_size == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << shamt;
    merged = (old_word & ~lane_mask) | ((q_wdata << shamt) & lane_mask);
    state_nx = state == IDLE ? (any_valid ? (s_err ? RESP : ACCESS) : IDLE) : state == ACCESS ? ((q_we & q_size != 2'b10) ? MERGE : RESP) : state == MERGE ? RESP : IDLE;
    rsp_on = reset_n & (state == RESP);
    rsp0_valid = rsp_on & ~q_port;
    rsp1_valid = rsp_on & q_port;
    rsp0_rdata = rsp0_valid ? rdata_q : '0;
    rsp1_rdata = rsp1_valid ? rdata_q : '0;
    rsp0_err = rsp0_valid & q_err;
    rsp1_err = rsp1_valid & q_err;
    mem_we = reset_n & ((state == ACCESS & q_we & q_size == 2'b10) | state == MERGE);
    mem_addr = (reset_n & (state == ACCESS | state == MERGE)) ? q_addr[DEPTH_LOG2+1:2] : '0;
    mem_wdata = !mem_we ? '0 : state == MERGE ? merged : q_wdata;
  end
  // State, round-robin pointer and latched request/response data
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      rr_last <= 1'b1;
      q_we <= 1'b0;
      q_uns <= 1'b0;
      q_port <= 1'b0;
      q_err <= 1'b0;
      q_addr <= '0;
      q_wdata <= '0;
      q_size <= '0;
      old_word <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (idle & any_valid) begin
        rr_last <= gnt;
        q_port <= gnt;
        q_we <= s_we;
        q_addr <= s_addr[DEPTH_LOG2+1:0];
        q_wdata <= s_wdata;
        q_size <= s_size;
        q_uns <= s_uns;
        q_err <= s_err;
        rdata_q <= '0;
      end
      if (state == ACCESS & ~q_we) rdata_q <= load_val;
      if (state == ACCESS) old_word <= mem_rdata;
    end
  end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Two-requester controller in front of the word-organised data RAM (64 x 32-bit, combinational read, synchronous write).
- Arbitrates port 0 (CPU load/store) and port 1 (loader/debug) with round-robin priority.
- Performs byte and halfword loads at any legal byte offset with sign/zero extension.
- Performs byte and halfword stores by read-modify-write, so neighbouring bytes are preserved; the RAM itself only writes whole words.

Parameters:
- DEPTH_LOG2, 6, word-index width; legal word addresses are 0 .. 2**DEPTH_LOG2-1.
- ADDR_W, 32, byte-address width of the request ports.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- reqN_valid  in  1  request pending (N = 0, 1); held until accepted.
- reqN_ready  out  1  acceptance pulse; the request transfers when valid and ready are both 1.
- reqN_we  in  1  1 = store, 0 = load.
- reqN_addr  in  ADDR_W  byte address.
- reqN_wdata  in  32  store data, right-aligned.
- reqN_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- reqN_unsigned  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
- rspN_valid  out  1  one-cycle completion pulse.
- rspN_rdata  out  32  load result, valid while rspN_valid is 1; 0 for stores and errors.
- rspN_err  out  1  error flag, valid while rspN_valid is 1.
- mem_addr  out  DEPTH_LOG2  word index to the RAM.
- mem_we  out  1  RAM word write enable.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  raw RAM word (combinational read).

Behaviour:
- Reset (reset_n = 0 at a clock edge):
  - State goes to IDLE; rr_last = 1, so port 0 wins the first tie.
  - All ready, rsp and mem outputs read 0; internal latches clear.
  - Reset mid-operation abandons the access: no write completes after reset, no rsp pulse is emitted, and the requester must re-issue.
- States: IDLE, ACCESS, MERGE, RESP.
- IDLE:
  - If exactly one valid is set, grant that port.
  - If both are set, grant the port not in rr_last.
  - Ready is combinational, asserted only in IDLE and only to the granted port.
  - On grant, latch we, addr, wdata, size, unsigned and port id; update rr_last.
  - Error check on the latched request: size = 11, halfword with addr[0] = 1, word with addr[1:0] != 0, or addr[ADDR_W-1:2] >= 2**DEPTH_LOG2. An error goes directly to RESP with err = 1 and no RAM access; otherwise go to ACCESS.
- ACCESS:
  - mem_addr = latched addr[DEPTH_LOG2+1:2].
  - Load: register the extracted lane from mem_rdata, then go to RESP.
    - Byte lane = addr[1:0]*8; halfword lane = addr[1]*16.
    - Extension is per unsigned.
  - Word store: mem_we = 1, mem_wdata = wdata, then go to RESP.
  - Sub-word store: capture mem_rdata into old_word, then go to MERGE.
- MERGE:
  - mem_we = 1.
  - mem_wdata = old_word with the selected byte or halfword lane replaced by wdata[7:0] or wdata[15:0].
  - Go to RESP.
- RESP:
  - rspN_valid = 1 for the latched port only, with rdata and err.
  - Go to IDLE. A new grant is possible in the following cycle, never in the RESP cycle.
- Latency, with acceptance in cycle T:
  - Error: rsp in T+1.
  - Load or word store: rsp in T+2.
  - Sub-word store: rsp in T+3.
- mem_we is 1 only in ACCESS (word store) or MERGE. It is never 1 on the error path.
- Only one transaction is outstanding at a time; ready stays 0 outside IDLE.
- Deasserting valid before acceptance is permitted and leaves no side effects.
- Priority rules:
  - rr_last updates only on grant.
  - A single requester is granted back-to-back, with one transaction every RESP+1 cycle.
  - With both ports continuously valid, grants alternate 0, 1, 0, 1.

Test Plan:
- Word store then load: port 0 stores 0xDEADBEEF to addr 0x10, then loads a word from 0x10. Required: store rsp at T+2 with err = 0; load rsp returns 0xDEADBEEF at T+2.
- Byte RMW: word 5 = 0x11223344; port 1 stores byte 0xAA to addr 0x16. Required: mem_we in the MERGE cycle only, word 5 becomes 0x11AA3344, rsp at T+3.
- Load extension: word 2 = 0x80F17F00.
  - Signed byte at 0x0A returns 0xFFFFFFF1.
  - Unsigned half at 0x0A returns 0x000080F1.
  - Signed half at 0x08 returns 0x00007F00.
- Error path:
  - Half load at 0x03, size = 11, and word store at 0x102 (index 64) each give err = 1 at T+1.
  - No mem_we pulse occurs and memory is unchanged.
- Arbitration: both ports hold valid for 4 transactions. Required: grants in order 0, 1, 0, 1; each rsp appears on the correct port only; rr_last starts with port 0 after reset.
- Reset in MERGE: assert reset_n = 0 during MERGE of a byte store. Required: no write (word unchanged), no rsp pulse, state IDLE and all outputs 0 on the next cycle.
